// File: rtl/code_entry.sv
// Keypad front end for the combination lock. It builds a BCD code from key strobes,
// submits the code to the comparator, reports its verdict and applies a timed lockout.
module code_entry #(
  parameter int DIGITS      = 4,
  parameter int IDLE_CYC    = 1000,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 5000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_key_valid,
  input  logic [3:0]            i_key_code,
  input  logic                  i_pass_in,
  input  logic                  i_fail_in,
  output logic [4*DIGITS-1:0]   o_data,
  output logic                  o_data_valid,
  output logic [2:0]            o_digit_cnt,
  output logic                  o_unlock,
  output logic                  o_err,
  output logic                  o_locked,
  output logic [1:0]            o_fail_cnt
);

  localparam int DW = 4 * DIGITS;
  localparam int IW = $clog2(IDLE_CYC + 1);
  localparam int LW = $clog2(LOCKOUT_CYC + 1);
  localparam logic [2:0] CNT_MAX = 3'(DIGITS);

  typedef enum logic [2:0] {
    S_ENTRY,
    S_SUBMIT,
    S_WAIT,
    S_CHECK,
    S_LOCKOUT
  } state_t;

  state_t          r_state, w_next;
  logic [DW-1:0]   r_data, w_data;
  logic [2:0]      r_cnt, w_cnt;
  logic [IW-1:0]   r_idle, w_idle;
  logic [LW-1:0]   r_lock, w_lock;
  logic [1:0]      r_fail, w_fail;
  logic            r_errEnter, w_errEnter;
  logic [1:0]      w_failInc;
  logic            w_dataValid, w_unlock, w_errCheck, w_locked;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_ENTRY;
      r_data     <= '0;
      r_cnt      <= '0;
      r_idle     <= '0;
      r_lock     <= '0;
      r_fail     <= '0;
      r_errEnter <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_data     <= w_data;
      r_cnt      <= w_cnt;
      r_idle     <= w_idle;
      r_lock     <= w_lock;
      r_fail     <= w_fail;
      r_errEnter <= w_errEnter;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_data      = r_data;
    w_cnt       = r_cnt;
    w_idle      = r_idle;
    w_lock      = '0;
    w_fail      = r_fail;
    w_errEnter  = 1'b0;
    w_dataValid = 1'b0;
    w_unlock    = 1'b0;
    w_errCheck  = 1'b0;
    w_locked    = 1'b0;
    w_failInc   = r_fail + 2'd1;

    case (r_state)
      S_ENTRY: begin
        if (i_key_valid) begin
          w_idle = '0;
          if (i_key_code <= 4'd9) begin
            if (r_cnt < CNT_MAX) begin
              w_data = {r_data[DW-5:0], i_key_code};
              w_cnt  = r_cnt + 3'd1;
            end
          end else if (i_key_code == 4'hA) begin
            if (r_cnt != 3'd0) begin
              w_data = r_data >> 4;
              w_cnt  = r_cnt - 3'd1;
            end
          end else if (i_key_code == 4'hB) begin
            w_data = '0;
            w_cnt  = '0;
          end else if (i_key_code == 4'hC) begin
            if (r_cnt == CNT_MAX) w_next = S_SUBMIT;
            else                  w_errEnter = 1'b1;
          end
        end else if (r_cnt != 3'd0) begin
          // An abandoned partial entry is dropped without any error report.
          if (r_idle == IW'(IDLE_CYC - 1)) begin
            w_data = '0;
            w_cnt  = '0;
            w_idle = '0;
          end else begin
            w_idle = r_idle + IW'(1);
          end
        end else begin
          w_idle = '0;
        end
      end
      S_SUBMIT: begin
        w_dataValid = 1'b1;
        w_next      = S_WAIT;
      end
      S_WAIT: w_next = S_CHECK;
      S_CHECK: begin
        // A pass that coincides with a fail is treated as a fail.
        w_data = '0;
        w_cnt  = '0;
        if (i_pass_in && !i_fail_in) begin
          w_unlock = 1'b1;
          w_fail   = '0;
          w_next   = S_ENTRY;
        end else begin
          w_errCheck = 1'b1;
          w_fail     = w_failInc;
          w_next     = (w_failInc == 2'(MAX_FAIL)) ? S_LOCKOUT : S_ENTRY;
        end
      end
      S_LOCKOUT: begin
        w_locked = 1'b1;
        if (r_lock == LW'(LOCKOUT_CYC - 1)) begin
          w_fail = '0;
          w_next = S_ENTRY;
        end else begin
          w_lock = r_lock + LW'(1);
        end
      end
      default: w_next = S_ENTRY;
    endcase
  end

  assign o_data       = r_data;
  assign o_digit_cnt  = r_cnt;
  assign o_data_valid = w_dataValid;
  assign o_unlock     = w_unlock;
  assign o_err        = r_errEnter | w_errCheck;
  assign o_locked     = w_locked;
  assign o_fail_cnt   = r_fail;

endmodule

// File: tb/tb_code_entry.sv
// Directed bench for code_entry: data_valid/unlock/err pulses are matched
// against a queue of expected events, and registers are checked step by step.
module tb_code_entry;

  localparam int DIGITS      = 4;
  localparam int IDLE_CYC    = 20;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 30;

  localparam int EV_SUBMIT = 0;
  localparam int EV_UNLOCK = 1;
  localparam int EV_ERR    = 2;

  typedef struct {
    int          kind;
    logic [15:0] data;
  } sbEntry_t;

  logic        clk;
  logic        rstN;
  logic        keyValid;
  logic [3:0]  keyCode;
  logic        passIn;
  logic        failIn;
  logic [15:0] data;
  logic        dataValid;
  logic [2:0]  digitCnt;
  logic        unlock;
  logic        err;
  logic        locked;
  logic [1:0]  failCnt;

  int checks   = 0;
  int failures = 0;
  sbEntry_t sbQueue[$];

  code_entry #(
    .DIGITS(DIGITS),
    .IDLE_CYC(IDLE_CYC),
    .MAX_FAIL(MAX_FAIL),
    .LOCKOUT_CYC(LOCKOUT_CYC)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rstN),
    .i_key_valid(keyValid),
    .i_key_code(keyCode),
    .i_pass_in(passIn),
    .i_fail_in(failIn),
    .o_data(data),
    .o_data_valid(dataValid),
    .o_digit_cnt(digitCnt),
    .o_unlock(unlock),
    .o_err(err),
    .o_locked(locked),
    .o_fail_cnt(failCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] code);
    keyValid = 1'b1;
    keyCode  = code;
    @(posedge clk);
    #1;
    keyValid = 1'b0;
    keyCode  = 4'hF;
  endtask

  task automatic pushEvent(input int kind, input logic [15:0] value);
    sbEntry_t e;
    e.kind = kind;
    e.data = value;
    sbQueue.push_back(e);
  endtask

  // Every verdict/submit pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rstN && (dataValid || unlock || err)) begin
      checkOutput("sb_unlock_err_exclusive", {31'd0, unlock & err}, 32'd0);
      if (sbQueue.size() == 0) begin
        checkOutput("sb_unexpected_pulse", {29'd0, dataValid, unlock, err}, 32'd0);
      end else begin
        sbEntry_t e;
        e = sbQueue.pop_front();
        checkOutput("sb_kind", dataValid ? EV_SUBMIT : (unlock ? EV_UNLOCK : EV_ERR), e.kind);
        if (e.kind == EV_SUBMIT) checkOutput("sb_data", {16'd0, data}, {16'd0, e.data});
      end
    end
  end

  initial begin
    int lockedCycles;

    rstN     = 1'b0;
    keyValid = 1'b0;
    keyCode  = 4'hF;
    passIn   = 1'b0;
    failIn   = 1'b0;
    tick();
    tick();
    checkOutput("rst_data", {16'd0, data}, 32'h0);
    checkOutput("rst_misc", {25'd0, dataValid, digitCnt, unlock, err, locked},  32'h0);
    checkOutput("rst_fail_cnt", {30'd0, failCnt}, 32'd0);
    rstN = 1'b1;
    tick();

    // Full entry accepted; keys in the submit window are dropped.
    passIn = 1'b1;
    applyStimulus(4'h1);
    applyStimulus(4'h2);
    applyStimulus(4'h3);
    applyStimulus(4'h4);
    checkOutput("t1_data", {16'd0, data}, 32'h1234);
    checkOutput("t1_cnt", {29'd0, digitCnt}, 32'd4);
    pushEvent(EV_SUBMIT, 16'h1234);
    pushEvent(EV_UNLOCK, 16'h0);
    applyStimulus(4'hC);
    checkOutput("t1_dv", {31'd0, dataValid}, 32'd1);
    applyStimulus(4'h7);
    checkOutput("t1_dv_single", {31'd0, dataValid}, 32'd0);
    checkOutput("t1_frozen", {16'd0, data}, 32'h1234);
    tick();
    checkOutput("t1_unlock", {31'd0, unlock}, 32'd1);
    tick();
    checkOutput("t1_unlock_pulse", {31'd0, unlock}, 32'd0);
    checkOutput("t1_cleared", {13'd0, digitCnt, data}, 32'h0);

    // Backspace and overflow.
    applyStimulus(4'h5);
    applyStimulus(4'h6);
    applyStimulus(4'hA);
    applyStimulus(4'h7);
    checkOutput("t2_bs_data", {16'd0, data}, 32'h0057);
    checkOutput("t2_bs_cnt", {29'd0, digitCnt}, 32'd2);
    applyStimulus(4'h8);
    applyStimulus(4'h9);
    applyStimulus(4'h1);
    checkOutput("t2_full_data", {16'd0, data}, 32'h5789);
    checkOutput("t2_full_cnt", {29'd0, digitCnt}, 32'd4);
    applyStimulus(4'hB);
    checkOutput("t2_clear", {13'd0, digitCnt, data}, 32'h0);
    applyStimulus(4'hA);
    checkOutput("t2_bs_empty", {13'd0, digitCnt, data}, 32'h0);

    // Premature enter.
    applyStimulus(4'h1);
    applyStimulus(4'h2);
    pushEvent(EV_ERR, 16'h0);
    applyStimulus(4'hC);
    checkOutput("t3_err", {31'd0, err}, 32'd1);
    checkOutput("t3_no_dv", {31'd0, dataValid}, 32'd0);
    checkOutput("t3_retained", {16'd0, data}, 32'h0012);
    checkOutput("t3_fail_cnt", {30'd0, failCnt}, 32'd0);
    tick();
    checkOutput("t3_err_pulse", {31'd0, err}, 32'd0);
    applyStimulus(4'hB);

    // Three consecutive failures lead to lockout.
    passIn = 1'b0;
    failIn = 1'b1;
    for (int i = 0; i < MAX_FAIL; i++) begin
      applyStimulus(4'(i));
      applyStimulus(4'h4);
      applyStimulus(4'h5);
      applyStimulus(4'h6);
      pushEvent(EV_SUBMIT, {4'(i), 12'h456});
      pushEvent(EV_ERR, 16'h0);
      applyStimulus(4'hC);
      tick();
      tick();
      checkOutput("t4_err", {31'd0, err}, 32'd1);
      tick();
      checkOutput("t4_fail_cnt", {30'd0, failCnt}, i + 1);
      checkOutput("t4_locked", {31'd0, locked}, (i == MAX_FAIL - 1) ? 32'd1 : 32'd0);
    end
    lockedCycles = locked ? 1 : 0;
    applyStimulus(4'h1);
    if (locked) lockedCycles++;
    applyStimulus(4'h2);
    if (locked) lockedCycles++;
    applyStimulus(4'hC);
    if (locked) lockedCycles++;
    checkOutput("t4_keys_ignored", {13'd0, digitCnt, data}, 32'h0);
    checkOutput("t4_fail_held", {30'd0, failCnt}, 32'd3);
    for (int n = 0; n < LOCKOUT_CYC + 20; n++) begin
      if (!locked) break;
      tick();
      if (locked) lockedCycles++;
    end
    checkOutput("t4_lock_len", lockedCycles, LOCKOUT_CYC);
    checkOutput("t4_unlocked", {31'd0, locked}, 32'd0);
    checkOutput("t4_fail_reset", {30'd0, failCnt}, 32'd0);
    failIn = 1'b0;

    // Idle timeout, and a key just before expiry restarts the timer.
    applyStimulus(4'h9);
    for (int n = 0; n < IDLE_CYC - 2; n++) tick();
    applyStimulus(4'h1);
    checkOutput("t5_restart", {16'd0, data}, 32'h0091);
    for (int n = 0; n < IDLE_CYC - 1; n++) tick();
    checkOutput("t5_not_yet", {13'd0, digitCnt, data}, {13'd0, 3'd2, 16'h0091});
    tick();
    checkOutput("t5_timeout", {13'd0, digitCnt, data}, 32'h0);
    checkOutput("t5_no_err", {31'd0, err}, 32'd0);

    // Reset while waiting for the verdict.
    passIn = 1'b1;
    applyStimulus(4'h1);
    applyStimulus(4'h2);
    applyStimulus(4'h3);
    applyStimulus(4'h4);
    pushEvent(EV_SUBMIT, 16'h1234);
    applyStimulus(4'hC);
    tick();
    rstN = 1'b0;
    #1;
    checkOutput("t6_rst_data", {16'd0, data}, 32'h0);
    checkOutput("t6_rst_misc", {23'd0, dataValid, digitCnt, unlock, err, locked, failCnt}, 32'h0);
    tick();
    tick();
    checkOutput("t6_no_unlock", {30'd0, unlock, err}, 32'd0);
    rstN = 1'b1;
    tick();
    applyStimulus(4'h3);
    checkOutput("t6_after", {16'd0, data}, 32'h0003);
    checkOutput("t6_after_cnt", {29'd0, digitCnt}, 32'd1);
    tick();
    checkOutput("sb_drained", sbQueue.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
